nios_system_nios2_cpu_mult_combine: RTL

NIOS_SYSTEM_NIOS2_CPU_MULT_COMBINE -- requirements
Module: nios_system_Nios2_cpu_mult_combine

---
 rtl/nios_system_nios2_cpu_mult_combine_if.sv | 33 +++
 rtl/nios_system_nios2_cpu_mult_combine.sv | 86 ++++++++
 2 files changed

// File: rtl/nios_system_nios2_cpu_mult_combine_if.sv
// Bus between the multiplier cell / pipeline control and the partial-product combiner.
// Handshake: the master presents partials with M_mul_start=1; they are taken on a rising
// edge only when M_en=1 and M_mul_flush=0. W_mul_result_valid marks a new result and is
// consumed on the next rising edge with M_en=1; while M_en=0 it and W_mul_result hold.
interface nios_system_nios2_cpu_mult_combine_if;
    logic [31:0] M_mul_cell_p1;
    logic [31:0] M_mul_cell_p2;
    logic [31:0] M_mul_cell_p3;
    logic [31:0] M_mul_cell_p4;
    logic        M_mul_start;
    logic        M_ctrl_mul_src1_signed;
    logic        M_ctrl_mul_src2_signed;
    logic        M_ctrl_mul_hi;
    logic        M_en;
    logic        M_mul_flush;
    logic [31:0] W_mul_result;
    logic        W_mul_result_valid;
    logic        mul_busy;

    modport master (
        output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_cell_p4,
        output M_mul_start, M_ctrl_mul_src1_signed, M_ctrl_mul_src2_signed,
        output M_ctrl_mul_hi, M_en, M_mul_flush,
        input  W_mul_result, W_mul_result_valid, mul_busy
    );

    modport slave (
        input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3, M_mul_cell_p4,
        input  M_mul_start, M_ctrl_mul_src1_signed, M_ctrl_mul_src2_signed,
        input  M_ctrl_mul_hi, M_en, M_mul_flush,
        output W_mul_result, W_mul_result_valid, mul_busy
    );
endinterface

// File: rtl/nios_system_nios2_cpu_mult_combine.sv
// Combines four 32-bit partial products of a 16x16-split multiplier into the selected
// 32-bit word of the 64-bit product: stage 1 sums the middle partials, stage 2 adds them in.
module nios_system_nios2_cpu_mult_combine #(
    parameter int RESULT_LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    nios_system_nios2_cpu_mult_combine_if.slave mul
);

    // Only the two-stage arrangement exists; any other latency never accepts an operation.
    localparam logic LATENCY_SUPPORTED = (RESULT_LATENCY == 2);

    logic [32:0] p2_ext;
    logic [32:0] p3_ext;
    logic [33:0] mid_d;

    logic        s1_valid;
    logic [31:0] s1_p1;
    logic [31:0] s1_p4;
    logic [33:0] s1_mid;
    logic        s1_hi;

    logic [63:0] mid_shifted;
    logic [63:0] product;
    logic [31:0] word_d;

    logic        s2_valid;
    logic [31:0] s2_word;

    logic        w_valid;
    logic [31:0] w_result;

    // The signedness flags only matter for the middle partials, so they are folded into
    // mid here and need not travel further down the pipe.
    always_comb begin
        p2_ext = {mul.M_ctrl_mul_src2_signed & mul.M_mul_cell_p2[31], mul.M_mul_cell_p2};
        p3_ext = {mul.M_ctrl_mul_src1_signed & mul.M_mul_cell_p3[31], mul.M_mul_cell_p3};
        mid_d  = {p2_ext[32], p2_ext} + {p3_ext[32], p3_ext};
    end

    always_comb begin
        mid_shifted = {{14{s1_mid[33]}}, s1_mid, 16'h0000};
        product     = {s1_p4, s1_p1} + mid_shifted;
        word_d      = s1_hi ? product[63:32] : product[31:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_p1    <= '0;
            s1_p4    <= '0;
            s1_mid   <= '0;
            s1_hi    <= 1'b0;
            s2_valid <= 1'b0;
            s2_word  <= '0;
            w_valid  <= 1'b0;
            w_result <= '0;
        end else if (mul.M_mul_flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            w_valid  <= 1'b0;
        end else if (mul.M_en) begin
            s1_valid <= mul.M_mul_start & LATENCY_SUPPORTED;
            if (mul.M_mul_start) begin
                s1_p1  <= mul.M_mul_cell_p1;
                s1_p4  <= mul.M_mul_cell_p4;
                s1_mid <= mid_d;
                s1_hi  <= mul.M_ctrl_mul_hi;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word <= word_d;
            end
            w_valid <= s2_valid;
            if (s2_valid) begin
                w_result <= s2_word;
            end
        end
    end

    assign mul.W_mul_result       = w_result;
    assign mul.W_mul_result_valid = w_valid;
    assign mul.mul_busy           = s1_valid | s2_valid;

endmodule
